// File: rtl/des_sbox_scheduler.sv
// DES round f-function S-box scheduler.
// Shares one S-box lookup port across the eight S-box lookups of a round.
// It takes the 48-bit key-mixed expansion word and issues one 6-bit lookup per
// cycle. Each 4-bit result is collected once it returns from the S-box port.
// When all eight results are in, the block presents the 32-bit word that feeds
// the P-permutation.
// Bit numbering: DES bit n of in_data sits at vector index 48-n, so S-box 1
// uses in_data[47:42] and returns its result in out_data[31:28].
module des_sbox_scheduler #(
    parameter int LOOKUP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        sb_req,
    output logic [2:0]  sb_sel,
    output logic [5:0]  sb_addr,
    input  logic [3:0]  sb_data,
    output logic        busy
);

    localparam int NUM_BOX = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [47:0] r_data;
    logic [2:0]  r_issue_idx;
    logic [2:0]  r_cap_idx;
    logic [31:0] r_out;

    logic        w_accept;
    logic        w_cap;
    logic        w_last_issue;
    logic        w_last_cap;
    logic [5:0]  w_chunk [0:NUM_BOX-1];

    // Split the latched word into the eight 6-bit S-box inputs.
    // DES bit 1 is the MSB.
    generate
        for (genvar gi = 0; gi < NUM_BOX; gi++) begin : g_chunk
            assign w_chunk[gi] = r_data[47-6*gi -: 6];
        end
    endgenerate

    // Lookup-return timing. With no latency, the result is captured in the
    // same cycle as the request. Otherwise, the request is delayed through a
    // shift chain so that the capture strobe lines up with returning data.
    // Reset clears the chain, so an aborted word leaves no stray captures.
    generate
        if (LOOKUP_LAT == 0) begin : g_lat0
            assign w_cap = sb_req;
        end else begin : g_latn
            logic [LOOKUP_LAT-1:0] r_req_dly;

            // Shift the request strobe LOOKUP_LAT stages toward the capture point.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_req_dly <= '0;
                end else begin
                    r_req_dly[0] <= sb_req;
                    for (int i = 1; i < LOOKUP_LAT; i++) begin
                        r_req_dly[i] <= r_req_dly[i-1];
                    end
                end
            end

            assign w_cap = r_req_dly[LOOKUP_LAT-1];
        end
    endgenerate

    assign w_accept     = in_valid && in_ready;
    assign w_last_issue = (r_issue_idx == 3'd7);
    assign w_last_cap   = w_cap && (r_cap_idx == 3'd7);

    // The select and address come straight from the issue counter and the
    // latched word. Between words, both registers are frozen, so sb_sel and
    // sb_addr hold their last values while sb_req is low.
    assign sb_sel   = r_issue_idx;
    assign sb_addr  = w_chunk[r_issue_idx];
    assign out_data = r_out;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, eight issue slots, optional drain, then hold
    // until the consumer takes the word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)     w_state_next = S_ISSUE;
            S_ISSUE: if (w_last_issue) w_state_next = (LOOKUP_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_last_cap)   w_state_next = S_DONE;
            S_DONE:  if (out_ready)    w_state_next = S_IDLE;
            default:                   w_state_next = S_IDLE;
        endcase
    end

    // State-decoded handshake and request outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sb_req    = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_ISSUE: sb_req    = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch the input word, advance the issue counter, and drop
    // each returning nibble into its slot of the result word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= '0;
            r_issue_idx <= '0;
            r_cap_idx   <= '0;
            r_out       <= '0;
        end else begin
            if (w_accept) begin
                r_data      <= in_data;
                r_issue_idx <= '0;
                r_cap_idx   <= '0;
            end else begin
                if (sb_req && !w_last_issue) begin
                    r_issue_idx <= r_issue_idx + 3'd1;
                end
                if (w_cap) begin
                    r_cap_idx <= r_cap_idx + 3'd1;
                    for (int i = 0; i < NUM_BOX; i++) begin
                        if (r_cap_idx == 3'(i)) begin
                            r_out[31-4*i -: 4] <= sb_data;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Bench for des_sbox_scheduler.
// Instance 0 runs with a combinational S-box bank. Instance 1 runs with a
// two-cycle registered S-box bank.
// A word-level model predicts the handshake timing, the lookup sequence and
// the result of every word. Directed vectors also pin known DES values.
module tb_des_sbox_scheduler;

    logic        clk;
    logic        rst;
    logic        iv   [2];
    logic [47:0] din  [2];
    logic        ordy [2];
    logic        irdy [2];
    logic        ov   [2];
    logic [31:0] dout [2];
    logic        sreq [2];
    logic [2:0]  ssel [2];
    logic [5:0]  saddr[2];
    logic        bsy  [2];
    logic [3:0]  sdat0;
    logic [3:0]  sdat1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Standard DES S-boxes, row-major: index = row*16 + column.
    logic [3:0] sbox_t [0:7][0:63] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [3:0] lookup(input logic [2:0] b, input logic [5:0] a);
        int r;
        int c;
        r = {a[5], a[0]};
        c = a[4:1];
        return sbox_t[b][r*16 + c];
    endfunction

    function automatic logic [5:0] chunk(input logic [47:0] w, input int k);
        return w[47-6*k -: 6];
    endfunction

    function automatic logic [31:0] sbox_word(input logic [47:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[31-4*k -: 4] = lookup(3'(k), chunk(w, k));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    des_sbox_scheduler #(.LOOKUP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]), .sb_req(sreq[0]),
        .sb_sel(ssel[0]), .sb_addr(saddr[0]), .sb_data(sdat0), .busy(bsy[0])
    );

    des_sbox_scheduler #(.LOOKUP_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]), .sb_req(sreq[1]),
        .sb_sel(ssel[1]), .sb_addr(saddr[1]), .sb_data(sdat1), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // S-box banks. Outside the valid return slot they drive noise, so a
    // mistimed capture corrupts the word.
    logic [7:0] noise;
    logic [3:0] p1;
    logic       v1;
    always @(posedge clk) noise <= 8'($urandom);
    always_comb sdat0 = sreq[0] ? lookup(ssel[0], saddr[0]) : noise[3:0];
    always @(posedge clk) begin
        p1    <= lookup(ssel[1], saddr[1]);
        v1    <= sreq[1];
        sdat1 <= v1 ? p1 : noise[7:4];
    end

    // Word-level model: per instance, whether a word is in flight, when it
    // was accepted and what it was.
    logic        m_known[2] = '{1'b0, 1'b0};
    logic        m_pend [2] = '{1'b0, 1'b0};
    int          m_acc  [2] = '{0, 0};
    logic [47:0] m_word [2];

    always @(negedge clk) begin
        int   lat;
        int   el;
        logic er;
        logic eo;
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 0 : 2;
            el  = cyc - m_acc[d];
            er  = m_pend[d] && el >= 1 && el <= 8;
            eo  = m_pend[d] && el >= 9 + lat;
            if (m_known[d]) begin
                chk($sformatf("d%0d in_ready", d), 64'(irdy[d]), 64'(!m_pend[d]));
                chk($sformatf("d%0d busy", d), 64'(bsy[d]), 64'(m_pend[d]));
                chk($sformatf("d%0d sb_req", d), 64'(sreq[d]), 64'(er));
                chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(eo));
                if (er) begin
                    chk($sformatf("d%0d sb_sel", d), 64'(ssel[d]), 64'(el - 1));
                    chk($sformatf("d%0d sb_addr", d), 64'(saddr[d]), 64'(chunk(m_word[d], el - 1)));
                end
                if (eo) chk($sformatf("d%0d out_data", d), 64'(dout[d]), 64'(sbox_word(m_word[d])));
            end
            if (rst) begin
                m_known[d] = 1'b1;
                m_pend[d]  = 1'b0;
            end else if (m_known[d]) begin
                if (!m_pend[d] && iv[d]) begin
                    m_pend[d] = 1'b1;
                    m_acc[d]  = cyc;
                    m_word[d] = din[d];
                end else if (eo && ordy[d]) begin
                    $display("word dut%0d in=%012h out=%08h lat=%0d", d, m_word[d], dout[d], el);
                    m_pend[d] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int d, input logic [47:0] w, output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        iv[d]  = 1'b1;
        din[d] = w;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (irdy[d]) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        if (!got) chk($sformatf("d%0d accept timeout", d), 64'd0, 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    // Directed word: checks every issue slot, the drain slots, the latency and
    // the result against the expected literal or model value.
    task automatic run_word(input int d, input logic [47:0] w, input logic [31:0] exp);
        int acc;
        int lat;
        lat = (d == 0) ? 0 : 2;
        send(d, w, acc);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("d%0d dir req k%0d", d, k), 64'(sreq[d]), 64'd1);
            chk($sformatf("d%0d dir sel k%0d", d, k), 64'(ssel[d]), 64'(k));
            chk($sformatf("d%0d dir addr k%0d", d, k), 64'(saddr[d]), 64'(chunk(w, k)));
        end
        for (int j = 0; j < lat; j++) begin
            @(negedge clk);
            chk($sformatf("d%0d drain req", d), 64'(sreq[d]), 64'd0);
            chk($sformatf("d%0d drain valid", d), 64'(ov[d]), 64'd0);
        end
        @(negedge clk);
        chk($sformatf("d%0d dir out_valid", d), 64'(ov[d]), 64'd1);
        chk($sformatf("d%0d dir latency", d), 64'(cyc - acc), 64'(9 + lat));
        chk($sformatf("d%0d dir out_data", d), 64'(dout[d]), 64'(exp));
    endtask

    initial begin
        int a0;
        int a1;
        bit got;
        logic [47:0] wb;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'b0;
            din[d]  = '0;
            ordy[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst in_ready", d), 64'(irdy[d]), 64'd1);
            chk($sformatf("d%0d rst out_valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("d%0d rst sb_req", d), 64'(sreq[d]), 64'd0);
            chk($sformatf("d%0d rst sb_sel", d), 64'(ssel[d]), 64'd0);
            chk($sformatf("d%0d rst sb_addr", d), 64'(saddr[d]), 64'd0);
            chk($sformatf("d%0d rst out_data", d), 64'(dout[d]), 64'd0);
            chk($sformatf("d%0d rst busy", d), 64'(bsy[d]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Known DES values on both latencies.
        run_word(0, 48'h0, 32'hEFA72C4D);
        run_word(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        run_word(1, 48'h0, 32'hEFA72C4D);
        run_word(1, 48'h0123_4567_89AB, sbox_word(48'h0123_4567_89AB));

        // Consumer stall in DONE.
        ordy[0] = 1'b0;
        run_word(0, 48'h0, 32'hEFA72C4D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", 64'(ov[0]), 64'd1);
            chk("stall out_data", 64'(dout[0]), 64'h0000_0000_EFA7_2C4D);
            chk("stall in_ready", 64'(irdy[0]), 64'd0);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("release out_valid", 64'(ov[0]), 64'd1);
        @(negedge clk);
        chk("release idle in_ready", 64'(irdy[0]), 64'd1);
        chk("release idle out_valid", 64'(ov[0]), 64'd0);

        // Back-to-back words with in_valid held high.
        wb = 48'hFEDC_BA98_7654;
        a0 = 0;
        a1 = 0;
        @(posedge clk); #1;
        iv[0]  = 1'b1;
        din[0] = 48'h0123_4567_89AB;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (irdy[0]) begin got = 1'b1; a0 = cyc; end
        end
        @(posedge clk); #1;
        din[0] = wb;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (irdy[0]) begin got = 1'b1; a1 = cyc; end
        end
        chk("b2b accept spacing", 64'(a1 - a0), 64'd10);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ov[0]) got = 1'b1;
        end
        chk("b2b second valid", 64'(got), 64'd1);
        chk("b2b second data", 64'(dout[0]), 64'(sbox_word(wb)));
        chk("b2b second latency", 64'(cyc - a1), 64'd9);

        // Abort during the fifth issue slot, then recover.
        send(0, 48'h1357_9BDF_0246, a0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort at k4 sel", 64'(ssel[0]), 64'd4);
        chk("abort at k4 req", 64'(sreq[0]), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort in_ready", 64'(irdy[0]), 64'd1);
        chk("abort out_valid", 64'(ov[0]), 64'd0);
        chk("abort sb_req", 64'(sreq[0]), 64'd0);
        chk("abort busy", 64'(bsy[0]), 64'd0);
        run_word(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);

        // A few arbitrary words against the model.
        for (int i = 0; i < 3; i++) begin
            wb = {16'($urandom), 32'($urandom)};
            run_word(1, wb, sbox_word(wb));
            wb = {16'($urandom), 32'($urandom)};
            run_word(0, wb, sbox_word(wb));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
